riscv_hwloop_controller: RTL and testbench
==========================================

RISCV_HWLOOP_CONTROLLER -- requirements
Module: riscv_hwloop_controller

Interface
REQ-001 The block SHALL have parameter N_REGS, default 2, giving the number of hardware loops; index 0 is the innermost and highest-priority loop.
REQ-002 The block SHALL have parameter N_REG_BITS, default $clog2(N_REGS), giving the loop index width.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port current_pc_i  input  32  PC of the instruction in decode.
REQ-006 The block SHALL have port pc_valid_i  input  1  the instruction at current_pc_i completes decode this cycle.
REQ-007 The block SHALL have port hwlp_start_addr_i  input  N_REGS x 32  loop start addresses from the loop registers.
REQ-008 The block SHALL have port hwlp_end_addr_i  input  N_REGS x 32  loop end addresses.
REQ-009 The block SHALL have port hwlp_counter_i  input  N_REGS x 32  remaining iteration counts.
REQ-010 The block SHALL have port hwlp_dec_cnt_o  output  N_REGS  one-hot decrement strobe to the loop registers.
REQ-011 The block SHALL have port jump_req_o  output  1  loop-back jump request to fetch.
REQ-012 The block SHALL have port jump_addr_o  output  32  jump target; valid while jump_req_o=1.
REQ-013 The block SHALL have port jump_ack_i  input  1  fetch has accepted the jump.
REQ-014 The block SHALL have port flush_i  input  1  branch or exception; cancels a pending jump.
REQ-015 The block SHALL have port busy_o  output  1  a jump is pending (FSM in JUMP_PEND).

Function
REQ-016 Loop k SHALL match when pc_valid_i=1, current_pc_i==hwlp_end_addr_i[k] and hwlp_counter_i[k]!=0.
REQ-017 In IDLE, when one or more loops match, the lowest matching index k SHALL be selected and hwlp_dec_cnt_o[k] SHALL pulse for exactly that cycle; all other bits SHALL be 0.
REQ-018 hwlp_dec_cnt_o SHALL be combinational and SHALL never have more than one bit set.
REQ-019 If the selected counter is greater than 1, the FSM SHALL go IDLE->JUMP_PEND and latch hwlp_start_addr_i[k] into jump_addr_o at the same edge.
REQ-020 If the selected counter equals 1, the block SHALL decrement only and stay IDLE, so execution falls through; no outer-loop jump SHALL occur in that cycle.
REQ-021 jump_req_o SHALL be registered, asserted from the cycle after the match and equal to (state==JUMP_PEND).
REQ-022 In JUMP_PEND, jump_req_o and jump_addr_o SHALL hold stable until jump_ack_i=1; at that edge the FSM SHALL return to IDLE.
REQ-023 In JUMP_PEND, matches SHALL be ignored: no decrement and no new latch.
REQ-024 flush_i=1 SHALL force IDLE at the next edge, dropping any pending jump; an already-issued decrement SHALL NOT be undone.
REQ-025 In IDLE, flush_i SHALL suppress hwlp_dec_cnt_o.
REQ-026 flush_i and jump_ack_i asserted in the same cycle SHALL be treated as a flush.
REQ-027 Counter comparisons SHALL be unsigned 32-bit; 0xFFFFFFFF is a valid count greater than 1.

Reset
REQ-028 While rst_n=0, the FSM SHALL be IDLE, jump_req_o=0, jump_addr_o=0, busy_o=0 and hwlp_dec_cnt_o=0, asynchronously.
REQ-029 Reset mid-JUMP_PEND SHALL discard the pending jump, and jump_req_o SHALL drop immediately.

Configuration
REQ-030 With macro RISCV_HWLOOP_STATS_EN defined, the block SHALL add output hwlp_jump_count_o[31:0], reset to 0, incremented (wrapping) on every jump_req_o & jump_ack_i & !flush_i cycle.
REQ-031 Without RISCV_HWLOOP_STATS_EN, the hwlp_jump_count_o port and its register SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-032 Bench: end0=0x100, start0=0x0F0, cnt0=3, pc=0x100 valid -> dec_cnt=01, jump_req next cycle with addr 0x0F0, held 2 cycles until ack.
REQ-033 Bench: cnt0=1, pc=end0 -> dec_cnt=01, jump_req stays 0, FSM stays IDLE.
REQ-034 Bench: end0=end1=0x200, cnt0=5, cnt1=2, pc=0x200 -> dec_cnt=01 only, jump target start0.
REQ-035 Bench: JUMP_PEND with flush_i=1 and jump_ack_i=1 together -> IDLE next cycle, jump_req=0, stats count unchanged.
REQ-036 Bench: rst_n low while jump_req=1 -> jump_req and busy drop without a clock edge, jump_addr=0.
REQ-037 Bench: cnt0=0, pc=end0 -> no decrement and no jump.

Source files
------------

// File: rtl/riscv_hwloop_controller.sv
// Hardware-loop controller: detects loop-end PCs, strobes the counter decrement and requests loop-back jumps.
// Optional jump statistics counter is enabled by defining RISCV_HWLOOP_STATS_EN.
module riscv_hwloop_controller #(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       current_pc_i,
  input  logic              pc_valid_i,
  input  logic [31:0]       hwlp_start_addr_i [N_REGS],
  input  logic [31:0]       hwlp_end_addr_i   [N_REGS],
  input  logic [31:0]       hwlp_counter_i    [N_REGS],
  output logic [N_REGS-1:0] hwlp_dec_cnt_o,
  output logic              jump_req_o,
  output logic [31:0]       jump_addr_o,
  input  logic              jump_ack_i,
  input  logic              flush_i,
`ifdef RISCV_HWLOOP_STATS_EN
  output logic [31:0]       hwlp_jump_count_o,
`endif
  output logic              busy_o
);

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    JUMP_PEND = 1'b1
  } state_e;

  state_e                state_q;
  logic                  jump_req_q;
  logic [31:0]           jump_addr_q;
  logic [N_REGS-1:0]     match_s;
  logic                  sel_valid_s;
  logic [N_REG_BITS-1:0] sel_idx_s;
  logic                  issue_s;

  // Per-loop match and lowest-index priority select
  always_comb begin
    match_s     = '0;
    sel_valid_s = 1'b0;
    sel_idx_s   = '0;
    for (int i = 0; i < N_REGS; i++) begin
      match_s[i] = pc_valid_i && (current_pc_i == hwlp_end_addr_i[i]) &&
                   (hwlp_counter_i[i] != 32'd0);
    end
    for (int i = N_REGS - 1; i >= 0; i--) begin
      if (match_s[i]) begin
        sel_valid_s = 1'b1;
        sel_idx_s   = N_REG_BITS'(i);
      end else begin
        sel_valid_s = sel_valid_s;
      end
    end
  end

  // Decrement strobe; rst_n gating keeps it quiet asynchronously during reset
  always_comb begin
    hwlp_dec_cnt_o = '0;
    issue_s = rst_n && (state_q == IDLE) && sel_valid_s && !flush_i;
    if (issue_s) begin
      hwlp_dec_cnt_o[sel_idx_s] = 1'b1;
    end else begin
      hwlp_dec_cnt_o = '0;
    end
  end

  // Jump FSM; flush dominates ack, a final iteration (count 1) falls through
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      jump_req_q  <= 1'b0;
      jump_addr_q <= 32'd0;
    end else if (flush_i) begin
      state_q    <= IDLE;
      jump_req_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (issue_s && (hwlp_counter_i[sel_idx_s] > 32'd1)) begin
            state_q     <= JUMP_PEND;
            jump_req_q  <= 1'b1;
            jump_addr_q <= hwlp_start_addr_i[sel_idx_s];
          end
        end
        JUMP_PEND: begin
          if (jump_ack_i) begin
            state_q    <= IDLE;
            jump_req_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          jump_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign jump_req_o  = jump_req_q;
  assign busy_o      = jump_req_q;
  assign jump_addr_o = jump_addr_q;

`ifdef RISCV_HWLOOP_STATS_EN
  logic [31:0] jump_count_q;
  logic [31:0] jump_count_d;

  // Count accepted (non-flushed) jumps, wrapping
  always_comb begin
    if (jump_req_q && jump_ack_i && !flush_i) begin
      jump_count_d = jump_count_q + 32'd1;
    end else begin
      jump_count_d = jump_count_q;
    end
  end

  // Statistics register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jump_count_q <= 32'd0;
    end else begin
      jump_count_q <= jump_count_d;
    end
  end

  assign hwlp_jump_count_o = jump_count_q;
`endif

endmodule

// File: tb/tb_riscv_hwloop_controller.sv
// Self-checking bench for riscv_hwloop_controller: directed scenarios then random traffic vs a behavioural model.
module tb_riscv_hwloop_controller;
  localparam int N = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   pc = 32'd0;
  logic          valid = 1'b0;
  logic [31:0]   start_a [N];
  logic [31:0]   end_a   [N];
  logic [31:0]   cnt_a   [N];
  logic [N-1:0]  dec_o;
  logic          jreq_o;
  logic [31:0]   jaddr_o;
  logic          ack = 1'b0;
  logic          flush = 1'b0;
  logic          busy_o;
`ifdef RISCV_HWLOOP_STATS_EN
  logic [31:0]   jcount_o;
`endif

  int checks = 0;
  int errors = 0;

  // reference model state: is a jump outstanding, where to, how many accepted
  bit          m_pend = 1'b0;
  logic [31:0] m_addr = 32'd0;
  logic [31:0] m_jumps = 32'd0;

  riscv_hwloop_controller #(.N_REGS(N)) dut (
    .clk(clk), .rst_n(rst_n), .current_pc_i(pc), .pc_valid_i(valid),
    .hwlp_start_addr_i(start_a), .hwlp_end_addr_i(end_a), .hwlp_counter_i(cnt_a),
    .hwlp_dec_cnt_o(dec_o), .jump_req_o(jreq_o), .jump_addr_o(jaddr_o),
    .jump_ack_i(ack), .flush_i(flush),
`ifdef RISCV_HWLOOP_STATS_EN
    .hwlp_jump_count_o(jcount_o),
`endif
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // index of the innermost loop whose end address is hit with a live count, or -1
  function automatic int lowest_match();
    if (!valid) return -1;
    for (int k = 0; k < N; k++)
      if (pc == end_a[k] && cnt_a[k] != 32'd0) return k;
    return -1;
  endfunction

  function automatic logic [31:0] model_dec();
    int k;
    k = lowest_match();
    if (m_pend || flush || k < 0) return 32'd0;
    return 32'd1 << k;
  endfunction

  task automatic model_step();
    int k;
    k = lowest_match();
    if (flush) m_pend = 1'b0;
    else if (m_pend) begin
      if (ack) begin m_pend = 1'b0; m_jumps = m_jumps + 32'd1; end
    end else if (k >= 0 && cnt_a[k] > 32'd1) begin
      m_pend = 1'b1;
      m_addr = start_a[k];
    end
  endtask

  task automatic check_regs();
    chk("jump_req", {31'd0, jreq_o}, {31'd0, m_pend});
    chk("busy", {31'd0, busy_o}, {31'd0, m_pend});
    if (m_pend) chk("jump_addr", jaddr_o, m_addr);
`ifdef RISCV_HWLOOP_STATS_EN
    chk("jump_count", jcount_o, m_jumps);
`endif
  endtask

  // one clock: drive inputs, check combinational strobe, advance, check registered outputs
  task automatic cyc(input logic [31:0] p, input logic v, input logic a, input logic f);
    @(negedge clk);
    pc = p; valid = v; ack = a; flush = f;
    #1;
    chk("dec_cnt", {30'd0, dec_o}, model_dec());
    @(posedge clk);
    model_step();
    #1;
    check_regs();
  endtask

  task automatic setloop(input int k, input logic [31:0] s, input logic [31:0] e, input logic [31:0] c);
    start_a[k] = s; end_a[k] = e; cnt_a[k] = c;
  endtask

  initial begin
    for (int k = 0; k < N; k++) setloop(k, 32'h0, 32'hFFFF_0000, 32'd0);
    #2;
    // reset state
    chk("rst_jump_req", {31'd0, jreq_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_jump_addr", jaddr_o, 32'd0);
    chk("rst_dec", {30'd0, dec_o}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // basic loop-back with two wait cycles before ack; matches ignored while pending
    setloop(0, 32'h0F0, 32'h100, 32'd3);
    cyc(32'h100, 1'b1, 1'b0, 1'b0);
    cyc(32'h100, 1'b1, 1'b0, 1'b0);
    cyc(32'h104, 1'b1, 1'b0, 1'b0);
    cyc(32'h0F0, 1'b1, 1'b1, 1'b0);
    cyc(32'h0F4, 1'b1, 1'b0, 1'b0);

    // last iteration falls through
    cnt_a[0] = 32'd1;
    cyc(32'h100, 1'b1, 1'b0, 1'b0);
    cyc(32'h104, 1'b1, 1'b0, 1'b0);

    // shared end address: innermost wins
    setloop(0, 32'h1A0, 32'h200, 32'd5);
    setloop(1, 32'h180, 32'h200, 32'd2);
    cyc(32'h200, 1'b1, 1'b0, 1'b0);
    chk("prio_target", jaddr_o, 32'h1A0);
    // flush together with ack counts as flush
    cyc(32'h1A0, 1'b1, 1'b1, 1'b1);
    // flush in IDLE suppresses the strobe
    cyc(32'h200, 1'b1, 1'b0, 1'b1);

    // reset asserted while a jump is pending
    cyc(32'h200, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_jump_req", {31'd0, jreq_o}, 32'd0);
    chk("arst_busy", {31'd0, busy_o}, 32'd0);
    chk("arst_jump_addr", jaddr_o, 32'd0);
    chk("arst_dec", {30'd0, dec_o}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    m_pend = 1'b0; m_addr = 32'd0; m_jumps = 32'd0;

    // zero count: no decrement, no jump; all-ones count is > 1
    setloop(1, 32'h0, 32'hFFFF_0000, 32'd0);
    cnt_a[0] = 32'd0;
    cyc(32'h200, 1'b1, 1'b0, 1'b0);
    cnt_a[0] = 32'hFFFF_FFFF;
    cyc(32'h200, 1'b1, 1'b0, 1'b0);
    cyc(32'h1A0, 1'b1, 1'b1, 1'b0);
    // invalid PC never matches
    cyc(32'h200, 1'b0, 1'b0, 1'b0);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pool [3];
      logic [31:0] cpool [5];
      pool[0] = 32'h100; pool[1] = 32'h200; pool[2] = 32'h300;
      for (int k = 0; k < N; k++) begin
        cpool[0] = 32'd0; cpool[1] = 32'd1; cpool[2] = 32'd2;
        cpool[3] = 32'hFFFF_FFFF; cpool[4] = $urandom_range(0, 6);
        setloop(k, $urandom & 32'hFFFF_FFFC, pool[$urandom_range(0, 2)], cpool[$urandom_range(0, 4)]);
      end
      cyc(pool[$urandom_range(0, 2)], ($urandom_range(0, 9) < 8), $urandom_range(0, 1) == 1,
          $urandom_range(0, 9) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
